// File: rtl/mac_sequencer.sv
// Dot-product sequencer: loads a bias, accumulates input*weight pairs over a
// valid/ready stream, then holds the result until the consumer takes it.
module mac_sequencer #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned LENGTH_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LENGTH_WIDTH-1:0] length,
    input  logic [DATA_WIDTH-1:0]   bias,
    output logic                    busy,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   input_value,
    input  logic [7:0]              weight_value,
    output logic [DATA_WIDTH-1:0]   result,
    output logic                    result_valid,
    input  logic                    result_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_d;
    logic [DATA_WIDTH-1:0]   acc;
    logic [DATA_WIDTH-1:0]   acc_d;
    logic [LENGTH_WIDTH-1:0] remaining;
    logic [LENGTH_WIDTH-1:0] remaining_d;

    // State, datapath and status flags; flags are decoded from the next state
    // so they line up exactly with the registered state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            remaining    <= '0;
            busy         <= 1'b0;
            in_ready     <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_d;
            acc          <= acc_d;
            remaining    <= remaining_d;
            busy         <= (state_d != IDLE);
            in_ready     <= (state_d == ACCUM);
            result_valid <= (state_d == DONE);
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state;
        acc_d       = acc;
        remaining_d = remaining;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_d       = bias;
                    remaining_d = length;
                    state_d     = (length == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    // Product truncated to the accumulator width; overflow wraps.
                    acc_d       = acc + DATA_WIDTH'(input_value * DATA_WIDTH'(weight_value));
                    remaining_d = remaining - LENGTH_WIDTH'(1);
                    if (remaining == LENGTH_WIDTH'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign result = acc;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed self-checking bench for mac_sequencer (default 32-bit data, 8-bit length).
module tb_mac_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  length;
    logic [31:0] bias;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] input_value;
    logic [7:0]  weight_value;
    logic [31:0] result;
    logic        result_valid;
    logic        result_ready;

    int checks;
    int errors;

    mac_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .length       (length),
        .bias         (bias),
        .busy         (busy),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .input_value  (input_value),
        .weight_value (weight_value),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; length = 8'd3; bias = 32'd55;
        in_valid = 1'b1; input_value = 32'd1; weight_value = 8'd1; result_ready = 1'b0;
        tick(); tick();
        checks++;
        if ({busy, in_ready, result_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got busy/in_ready/result_valid=%b expected 000",
                     {busy, in_ready, result_valid});
        end
        checks++;
        if (result !== 32'd0) begin
            errors++;
            $display("FAIL reset_result: got %0d expected 0", result);
        end
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b in_ready=%b expected 0 0", busy, in_ready);
        end
    endtask

    task automatic test_basic();
        result_ready = 1'b1;
        start = 1'b1; length = 8'd3; bias = 32'd10;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_accum_entry: got busy=%b in_ready=%b expected 1 1", busy, in_ready);
        end
        in_valid = 1'b1; input_value = 32'd2; weight_value = 8'd3;
        tick();
        input_value = 32'd4; weight_value = 8'd5;
        tick();
        input_value = 32'd1; weight_value = 8'd255;
        checks++;
        if (result_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid: got result_valid=%b expected 0", result_valid);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (result_valid !== 1'b1 || result !== 32'd291) begin
            errors++;
            $display("FAIL basic_result: got valid=%b result=%0d expected 1 291", result_valid, result);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_in_ready: got %b expected 0", in_ready);
        end
        tick();
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_one_cycle_valid: got valid=%b busy=%b expected 0 0", result_valid, busy);
        end
    endtask

    task automatic test_zero_length();
        result_ready = 1'b1; in_valid = 1'b1; input_value = 32'd9; weight_value = 8'd9;
        start = 1'b1; length = 8'd0; bias = 32'd7;
        tick();
        start = 1'b0;
        checks++;
        if (result_valid !== 1'b1 || result !== 32'd7 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_length: got valid=%b result=%0d in_ready=%b expected 1 7 0",
                     result_valid, result, in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (result_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_length_return: got valid=%b in_ready=%b busy=%b expected 0 0 0",
                     result_valid, in_ready, busy);
        end
    endtask

    task automatic test_stall_backpressure();
        result_ready = 1'b0;
        start = 1'b1; length = 8'd2; bias = 32'd0;
        tick();
        start = 1'b0;
        in_valid = 1'b1; input_value = 32'd5; weight_value = 8'd2;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            // Start during ACCUM must not reload acc/remaining or change state.
            start = (i == 1); length = 8'd9; bias = 32'd99;
            tick();
            start = 1'b0;
            checks++;
            if (in_ready !== 1'b1 || result_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got in_ready=%b valid=%b expected 1 0",
                         i, in_ready, result_valid);
            end
        end
        in_valid = 1'b1; input_value = 32'd1; weight_value = 8'd1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (result_valid !== 1'b1 || result !== 32'd11) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: got valid=%b result=%0d expected 1 11",
                         i, result_valid, result);
            end
            start = (i == 2); length = 8'd1; bias = 32'd77;
            if (i != 3) tick();
        end
        // Start coincident with the DONE->IDLE handshake is ignored.
        start = 1'b1; length = 8'd1; bias = 32'd77; result_ready = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL handshake_start_ignored: got busy=%b valid=%b expected 0 0", busy, result_valid);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_stays_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_wrap();
        result_ready = 1'b1;
        start = 1'b1; length = 8'd1; bias = 32'hFFFF_FFFF;
        tick();
        start = 1'b0;
        in_valid = 1'b1; input_value = 32'd1; weight_value = 8'd1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (result_valid !== 1'b1 || result !== 32'd0) begin
            errors++;
            $display("FAIL wrap: got valid=%b result=%0d expected 1 0", result_valid, result);
        end
        tick();
    endtask

    task automatic test_max_length();
        result_ready = 1'b1;
        start = 1'b1; length = 8'hFF; bias = 32'd0;
        tick();
        start = 1'b0;
        in_valid = 1'b1; input_value = 32'h8000_0001; weight_value = 8'd2;
        for (int i = 0; i < 254; i++) tick();
        checks++;
        if (result_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL max_length_254: got valid=%b in_ready=%b expected 0 1", result_valid, in_ready);
        end
        tick();
        in_valid = 1'b0;
        // 255 * (2^32+2) mod 2^32 = 510
        checks++;
        if (result_valid !== 1'b1 || result !== 32'd510) begin
            errors++;
            $display("FAIL max_length_result: got valid=%b result=%0d expected 1 510", result_valid, result);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        result_ready = 1'b1;
        start = 1'b1; length = 8'd4; bias = 32'd5;
        tick();
        start = 1'b0;
        in_valid = 1'b1; input_value = 32'd3; weight_value = 8'd4;
        tick(); tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({busy, in_ready, result_valid} !== 3'b000 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: got flags=%b result=%0d expected 000 0",
                     {busy, in_ready, result_valid}, result);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (result_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_no_result[%0d]: got valid=%b busy=%b expected 0 0",
                         i, result_valid, busy);
            end
        end
        in_valid = 1'b0;
        start = 1'b1; length = 8'd1; bias = 32'd0;
        tick();
        start = 1'b0;
        in_valid = 1'b1; input_value = 32'd3; weight_value = 8'd3;
        tick();
        in_valid = 1'b0;
        checks++;
        if (result_valid !== 1'b1 || result !== 32'd9) begin
            errors++;
            $display("FAIL reset_fresh_op: got valid=%b result=%0d expected 1 9", result_valid, result);
        end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_zero_length();
        test_stall_backpressure();
        test_wrap();
        test_max_length();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the width of data, bias and accumulator.
REQ-002 SHALL have parameter LENGTH_WIDTH, default 8, giving the width of the vector-length field.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to begin a dot product.
REQ-006 SHALL have port length, input, LENGTH_WIDTH bits: number of input/weight pairs, sampled on an accepted start.
REQ-007 SHALL have port bias, input, DATA_WIDTH bits: initial accumulator value, sampled on an accepted start.
REQ-008 SHALL have port busy, output, 1 bit: high when the state is not IDLE.
REQ-009 SHALL have port in_valid, input, 1 bit: input_value and weight_value are valid.
REQ-010 SHALL have port in_ready, output, 1 bit: the sequencer can accept a pair.
REQ-011 SHALL have port input_value, input, DATA_WIDTH bits: operand stream.
REQ-012 SHALL have port weight_value, input, 8 bits: unsigned weight stream.
REQ-013 SHALL have port result, output, DATA_WIDTH bits: final accumulator.
REQ-014 SHALL have port result_valid, output, 1 bit: result is valid.
REQ-015 SHALL have port result_ready, input, 1 bit: the consumer accepts result.

Function
REQ-016 SHALL implement the states IDLE, ACCUM and DONE.
REQ-017 In IDLE, start=1 SHALL load acc<=bias and remaining<=length; the next state SHALL be ACCUM if length!=0 and DONE if length==0.
REQ-018 start SHALL be ignored in ACCUM and DONE, with no effect on acc, remaining or state.
REQ-019 in_ready SHALL be 1 exactly when the state is ACCUM; it SHALL be 0 in IDLE and DONE, independent of in_valid.
REQ-020 A pair SHALL be accepted on a cycle with in_valid && in_ready.
- On acceptance: acc <= acc + input_value*weight_value, truncated mod 2^DATA_WIDTH.
- input_value and weight_value are both unsigned.
- remaining <= remaining-1.
REQ-021 Cycles in ACCUM with in_valid=0 SHALL hold acc and remaining unchanged, with no limit on the number of stall cycles.
REQ-022 When the last pair is accepted (remaining==1), the next state SHALL be DONE, and acc SHALL include that pair.
REQ-023 The pair-to-result latency SHALL be 1 cycle.
- result_valid is 1 in the cycle after the last accepted pair.
- result_valid is registered, high exactly when the state is DONE.
REQ-024 result SHALL equal acc and SHALL stay stable while result_valid=1.
REQ-025 In DONE, result_ready=1 SHALL return the state to IDLE on the next cycle; result_ready=0 SHALL hold the DONE state indefinitely.
REQ-026 A start asserted in the same cycle as the DONE->IDLE handshake SHALL be ignored; a new start is accepted only while in IDLE.
REQ-027 length is an unsigned count; length equal to all ones SHALL process 2^LENGTH_WIDTH-1 pairs, and remaining SHALL never wrap below 0.
REQ-028 Accumulator overflow SHALL wrap silently, with no saturation and no flag.
REQ-029 Back-to-back transfers SHALL be supported: one pair per cycle while in_valid stays 1.

Reset
REQ-030 rst=1 at a clock edge SHALL force: state IDLE, acc=0, remaining=0, busy=0, in_ready=0, result_valid=0, result=0.
REQ-031 rst SHALL take priority over start, handshakes and every state transition.
REQ-032 A reset mid-operation (in ACCUM or DONE) SHALL discard the partial result.
- No result_valid pulse is emitted for the discarded operation.
- The first start after rst is released behaves as a fresh operation.

Verification
REQ-033 Basic: bias=10, length=3, pairs (2,3),(4,5),(1,255) back-to-back, result_ready=1 -> result=10+6+20+255=291.
- result_valid is high 1 cycle after the third pair and for exactly 1 cycle.
REQ-034 Zero length: bias=7, length=0 -> the cycle after start, result_valid=1 and result=7; in_ready stays 0 throughout.
REQ-035 Stalls and backpressure: length=2 with 3 idle in_valid=0 cycles between the pairs (5,2),(1,1), and result_ready held 0 for 4 cycles -> result=11 held stable for all 4 cycles.
- A start pulsed during ACCUM and during DONE is ignored.
REQ-036 Wrap: DATA_WIDTH=32, bias=32'hFFFF_FFFF, pair (1,1) -> result=0.
REQ-037 Reset mid-operation: assert rst after 2 of 4 pairs -> all outputs are at reset values next cycle.
- Then bias=0, length=1, pair (3,3) -> result=9.
